// File: rtl/bitcount_scheduler.sv
// Shared iterative CTZ / CLZ / CPOP engine for two issue lanes.
// A round-robin arbiter accepts one request at a time. The engine scans CHUNK
// bits per busy cycle, with early exit for CTZ/CLZ. A tagged result is returned
// over a valid/ready port.
module bitcount_scheduler #(
    parameter int unsigned CHUNK = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [31:0]      req0_src,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [31:0]      req1_src,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_lane
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [1:0] OP_CLZ  = 2'b01;
    localparam logic [1:0] OP_CPOP = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;
    localparam logic [5:0] STEP    = 6'(CHUNK);
    localparam logic [5:0] LAST_IX = 6'(32 - CHUNK);

    state_t           state, state_nx;
    logic             rr_last;
    logic [31:0]      src_q;
    logic [1:0]       op_q;
    logic [5:0]       cnt, idx;

    logic             grant, accept;
    logic [1:0]       sel_op;
    logic [31:0]      sel_src, sel_rev;
    logic [TAG_W-1:0] sel_tag;

    logic [CHUNK-1:0] chunk;
    logic [5:0]       chunk_tz, chunk_pop, cnt_nx;
    logic             chunk_hit, is_cpop, finish;

    // Round-robin arbitration and request selection; readies held low in reset and flush.
    always_comb begin
        if (req0_valid && req1_valid) grant = ~rr_last;
        else                          grant = req1_valid;
        req0_ready = (state == IDLE) && !flush && !rst && req0_valid && !grant;
        req1_ready = (state == IDLE) && !flush && !rst && req1_valid &&  grant;
        accept     = req0_ready || req1_ready;
        sel_op     = grant ? req1_op  : req0_op;
        sel_src    = grant ? req1_src : req0_src;
        sel_tag    = grant ? req1_tag : req0_tag;
        sel_rev    = '0;
        for (int unsigned i = 0; i < 32; i++) sel_rev[i] = sel_src[31 - i];
    end

    // Per-chunk trailing-zero and popcount; CLZ operands were reversed at capture.
    always_comb begin
        chunk     = src_q[CHUNK-1:0];
        chunk_tz  = STEP;
        chunk_hit = 1'b0;
        chunk_pop = '0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            chunk_pop = chunk_pop + 6'(chunk[i]);
            if (!chunk_hit && chunk[i]) begin
                chunk_tz  = 6'(i);
                chunk_hit = 1'b1;
            end
        end
        is_cpop = (op_q == OP_CPOP);
        cnt_nx  = cnt + (is_cpop ? chunk_pop : chunk_tz);
        finish  = (idx == LAST_IX) || (!is_cpop && chunk_hit);
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (sel_op == OP_RSVD) ? DONE : BUSY;
            BUSY: if (finish) state_nx = DONE;
            DONE: if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Operand capture, chunk scan and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last  <= 1'b1;
            src_q    <= '0;
            op_q     <= '0;
            cnt      <= '0;
            idx      <= '0;
            res_data <= '0;
            res_tag  <= '0;
            res_lane <= 1'b0;
        end else if (accept) begin
            rr_last  <= grant;
            src_q    <= (sel_op == OP_CLZ) ? sel_rev : sel_src;
            op_q     <= sel_op;
            cnt      <= '0;
            idx      <= '0;
            res_data <= '0;
            res_tag  <= sel_tag;
            res_lane <= grant;
        end else if (state == BUSY && !flush) begin
            src_q <= src_q >> CHUNK;
            cnt   <= cnt_nx;
            idx   <= idx + STEP;
            if (finish) res_data <= {26'b0, cnt_nx};
        end
    end

    // Result valid exactly while the finished result is held.
    always_comb res_valid = (state == DONE);

endmodule

// File: tb/tb_bitcount_scheduler.sv
// Scoreboard bench for bitcount_scheduler (CHUNK=4, TAG_W=4).
module tb_bitcount_scheduler;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_src, req1_src;
    logic [3:0]  req0_tag, req1_tag;
    logic        res_valid, res_ready, res_lane;
    logic [31:0] res_data;
    logic [3:0]  res_tag;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        lane;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, rise_cyc = 0, hs_cyc = 0, acc_cyc = 0;
    logic prev_v = 1'b0;

    bitcount_scheduler #(.CHUNK(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_src(req0_src), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_src(req1_src), .req1_tag(req1_tag),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_lane(res_lane)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, got, got, exp, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] src);
        int n = 0;
        bit hit = 0;
        case (op)
            2'b00: begin
                for (int i = 0; i < 32; i++) if (!hit) begin
                    if (src[i]) hit = 1; else n++;
                end
            end
            2'b01: begin
                for (int i = 31; i >= 0; i--) if (!hit) begin
                    if (src[i]) hit = 1; else n++;
                end
            end
            2'b10: n = $countones(src);
            default: n = 0;
        endcase
        return 32'(n);
    endfunction

    function automatic int latency(input logic [1:0] op, input logic [31:0] src, input logic [31:0] r);
        if (op == 2'b11) return 1;
        if (op == 2'b10 || src == 0) return 9;
        return int'(r) / 4 + 2;
    endfunction

    // Result monitor: exclusivity of readies, rise time tracking, scoreboard pop.
    always @(negedge clk) begin
        exp_t e;
        check("ready_excl", {31'b0, req0_ready & req1_ready}, 32'd0);
        if (res_valid && !prev_v) rise_cyc = cyc;
        prev_v = res_valid;
        if (res_valid && res_ready && !flush && !rst) begin
            hs_cyc = cyc;
            if (sbq.size() == 0) check("unexpected_result", 32'd1, 32'd0);
            else begin
                e = sbq.pop_front();
                check("res_data", res_data, e.data);
                check("res_tag", {28'b0, res_tag}, {28'b0, e.tag});
                check("res_lane", {31'b0, res_lane}, {31'b0, e.lane});
                check("latency", 32'(rise_cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input bit lane, input logic [1:0] op, input logic [31:0] src,
                         input logic [3:0] tag, input bit expect_res);
        bit   done = 0;
        exp_t e;
        if (lane) begin req1_op = op; req1_src = src; req1_tag = tag; req1_valid = 1; end
        else      begin req0_op = op; req0_src = src; req0_tag = tag; req0_valid = 1; end
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (lane ? req1_ready : req0_ready) begin
                done = 1;
                acc_cyc = cyc;
                if (expect_res) begin
                    e.data = model(op, src);
                    e.tag  = tag;
                    e.lane = lane;
                    e.lat  = latency(op, src, e.data);
                    e.acc  = cyc;
                    sbq.push_back(e);
                end
            end
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (lane) req1_valid = 0; else req0_valid = 0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !res_valid) ok = 1;
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (res_valid) ok = 1;
        end
        if (!ok) check("valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fcyc, g;
        rst = 1; flush = 0; res_ready = 1;
        req0_valid = 1; req1_valid = 1;
        req0_op = 0; req1_op = 0; req0_src = 1; req1_src = 1; req0_tag = 0; req1_tag = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", {31'b0, res_valid}, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_tag", {28'b0, res_tag}, 0);
        check("rst_res_lane", {31'b0, res_lane}, 0);
        check("rst_req0_ready", {31'b0, req0_ready}, 0);
        check("rst_req1_ready", {31'b0, req1_ready}, 0);
        req0_valid = 0; req1_valid = 0; rst = 0;
        @(posedge clk); #1;

        // Directed latency/result cases, then random ones.
        issue(0, 2'b00, 32'h0000_0008, 4'd5, 1); wait_idle();
        issue(1, 2'b00, 32'h0000_0000, 4'd9, 1); wait_idle();
        issue(0, 2'b01, 32'h0001_0000, 4'd2, 1); wait_idle();
        issue(1, 2'b10, 32'hF0F0_F0F0, 4'd6, 1); wait_idle();
        issue(0, 2'b11, 32'h1234_5678, 4'd4, 1); wait_idle();
        issue(1, 2'b01, 32'h8000_0000, 4'd3, 1); wait_idle();
        issue(0, 2'b00, 32'h8000_0000, 4'd1, 1); wait_idle();
        for (int i = 0; i < 8; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  $urandom << $urandom_range(0, 31), 4'($urandom), 1);
            wait_idle();
        end

        // Backpressure: result held stable, no accept, then accept right after handshake.
        res_ready = 0;
        issue(0, 2'b00, 32'h0000_0010, 4'd7, 1);
        req1_op = 0; req1_src = 32'h4; req1_tag = 4'd8; req1_valid = 1;
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", {31'b0, res_valid}, 1);
            check("hold_data", res_data, 4);
            check("hold_tag", {28'b0, res_tag}, 7);
            check("hold_req1_ready", {31'b0, req1_ready}, 0);
        end
        @(posedge clk); #1;
        res_ready = 1;
        issue(1, 2'b00, 32'h0000_0004, 4'd8, 1);
        check("accept_after_hs", 32'(acc_cyc - hs_cyc), 1);
        wait_idle();

        // Flush in DONE with res_ready high drops the result.
        res_ready = 0;
        issue(0, 2'b10, 32'h0000_00FF, 4'd1, 0);
        wait_valid();
        @(posedge clk); #1;
        flush = 1; res_ready = 1;
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk);
        check("flush_done_valid", {31'b0, res_valid}, 0);
        @(posedge clk); #1;

        // Flush alongside a request in IDLE blocks the accept.
        flush = 1; req0_valid = 1; req0_op = 0; req0_src = 1; req0_tag = 2;
        @(negedge clk);
        check("flush_blocks_ready", {31'b0, req0_ready}, 0);
        @(posedge clk); #1;
        flush = 0; req0_valid = 0;
        repeat (2) begin
            @(negedge clk);
            check("flush_no_accept", {31'b0, res_valid}, 0);
        end
        @(posedge clk); #1;

        // Flush in second BUSY cycle of CPOP, new request next cycle.
        issue(0, 2'b10, 32'hF0F0_F0F0, 4'd1, 0);
        @(posedge clk); #1;
        flush = 1;
        @(negedge clk);
        fcyc = cyc;
        @(posedge clk); #1;
        flush = 0;
        issue(1, 2'b00, 32'h0000_0002, 4'd3, 1);
        check("flush_reaccept", 32'(acc_cyc - fcyc), 1);
        wait_idle();
        repeat (10) begin
            @(negedge clk);
            check("flush_no_result", {31'b0, res_valid}, 0);
        end
        @(posedge clk); #1;

        // Asynchronous reset while a result is held.
        res_ready = 0;
        issue(1, 2'b00, 32'h0000_0001, 4'hB, 0);
        wait_valid();
        #1 rst = 1;
        #1;
        check("arst_done_valid", {31'b0, res_valid}, 0);
        check("arst_done_tag", {28'b0, res_tag}, 0);
        check("arst_done_lane", {31'b0, res_lane}, 0);
        @(posedge clk); #1;
        rst = 0; res_ready = 1;
        @(posedge clk); #1;

        // Asynchronous reset mid-BUSY.
        issue(0, 2'b10, 32'hF0F0_F0F0, 4'hA, 0);
        #1 rst = 1;
        #1;
        check("arst_busy_valid", {31'b0, res_valid}, 0);
        check("arst_busy_data", res_data, 0);
        check("arst_busy_tag", {28'b0, res_tag}, 0);
        req0_valid = 1; req1_valid = 1;
        #1;
        check("arst_busy_ready0", {31'b0, req0_ready}, 0);
        check("arst_busy_ready1", {31'b0, req1_ready}, 0);
        @(posedge clk); #1;

        // Both lanes requesting continuously after reset: grants alternate from lane 0.
        req0_op = 0; req0_src = 1; req0_tag = 4'd1;
        req1_op = 0; req1_src = 1; req1_tag = 4'd2;
        rst = 0;
        g = 0;
        for (int n = 0; n < 60 && g < 4; n++) begin
            exp_t e;
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                check("rr_grant", {31'b0, req1_ready}, 32'(g % 2));
                e.data = 0;
                e.tag  = req1_ready ? 4'd2 : 4'd1;
                e.lane = req1_ready;
                e.lat  = 2;
                e.acc  = cyc;
                sbq.push_back(e);
                g++;
            end
        end
        if (g < 4) check("rr_timeout", 32'(g), 4);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
